// File: rtl/tb_sim_watchdog_pkg.sv
// Shared types and helpers for the simulation watchdog: FSM state encoding,
// X-error counter width and a saturating increment.
package tb_sim_watchdog_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } wd_state_e;

  localparam int X_CNT_W = 16;

  function automatic logic [X_CNT_W-1:0] sat_inc(input logic [X_CNT_W-1:0] v);
    return (&v) ? v : v + X_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tb_sim_watchdog_if.sv
// Signal bundle between a test sequence (master) and the watchdog (slave).
// All signals are level-sampled on every rising clk edge; there is no valid/ready
// handshake: inputs are taken as-is each cycle and outputs are registered status.
interface tb_sim_watchdog_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int LIMIT_W = 16
);
  import tb_sim_watchdog_pkg::*;

  logic [NUM_CH-1:0]         ch_arm;
  logic [NUM_CH-1:0]         ch_active;
  logic [NUM_CH*LIMIT_W-1:0] ch_limit;
  logic [DATA_W-1:0]         mon_vec;
  logic                      test_done;
  logic [NUM_CH-1:0]         ch_timeout;
  logic                      glob_timeout;
  logic [X_CNT_W-1:0]        x_err_cnt;
  logic [1:0]                state_o;

  modport master (
    output ch_arm, ch_active, ch_limit, mon_vec, test_done,
    input  ch_timeout, glob_timeout, x_err_cnt, state_o
  );

  modport slave (
    input  ch_arm, ch_active, ch_limit, mon_vec, test_done,
    output ch_timeout, glob_timeout, x_err_cnt, state_o
  );

endinterface

// File: rtl/tb_sim_watchdog_chan.sv
// One inactivity watchdog channel: saturating idle counter, combinational
// limit match and a sticky timeout flag.
module tb_sim_watchdog_chan #(
  parameter int LIMIT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               arm,
  input  logic               active,
  input  logic [LIMIT_W-1:0] limit,
  output logic               timeout_hit,
  output logic               flag
);

  logic [LIMIT_W-1:0] cnt;

  // Activity in the match cycle rescues the channel; a zero limit disables it.
  assign timeout_hit = arm && !active && (limit != '0) && (cnt == limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (run) begin
      if (!arm || active) begin
        cnt <= '0;
      end else if (!(&cnt)) begin
        cnt <= cnt + LIMIT_W'(1);
      end
      if (timeout_hit) begin
        flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tb_sim_watchdog.sv
// Simulation supervisor: per-channel inactivity watchdogs, global run-length
// watchdog and optional X-check on mon_vec (enabled by TB_SIM_WATCHDOG_X_CHECK_EN).
module tb_sim_watchdog
  import tb_sim_watchdog_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 32,
  parameter int LIMIT_W        = 16,
  parameter int GLOBAL_TIMEOUT = 10000,
  parameter int RST_HOLDOFF    = 2,
  parameter int FATAL_ON_FAIL  = 1,
  // 0 silences the timeout $error/$fatal messages for benches that provoke FAIL on purpose.
  parameter int ERR_MSG_EN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  tb_sim_watchdog_if.slave  wd
);

  localparam int GLOB_W = (GLOBAL_TIMEOUT > 1) ? $clog2(GLOBAL_TIMEOUT + 1) : 1;
  localparam int HOLD_W = (RST_HOLDOFF > 0) ? $clog2(RST_HOLDOFF + 1) : 1;
  localparam logic [GLOB_W-1:0] GLOB_LIM = GLOB_W'(GLOBAL_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(RST_HOLDOFF);

  wd_state_e         state_q;
  wd_state_e         state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GLOB_W-1:0] glob_cnt;
  logic              glob_flag;
  logic              glob_hit;
  logic              run;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_flag;

  assign run      = (state_q == RUN);
  assign glob_hit = run && (glob_cnt == GLOB_LIM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: if (hold_cnt == HOLD_LIM) state_d = RUN;
      // A timeout in the same cycle as test_done still fails the run.
      RUN: begin
        if (glob_hit || (|ch_hit)) state_d = FAIL;
        else if (wd.test_done)     state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
      if ((ERR_MSG_EN != 0) && (state_q == RUN) && (state_d == FAIL)) begin
        $error("tb_sim_watchdog timeout: channels=%b global=%b", ch_hit, glob_hit);
        if (FATAL_ON_FAIL != 0) begin
          $fatal(1, "tb_sim_watchdog timeout: channels=%b global=%b", ch_hit, glob_hit);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state_q == HOLD) && (hold_cnt != HOLD_LIM)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glob_cnt  <= '0;
      glob_flag <= 1'b0;
    end else if (run) begin
      if (glob_cnt != GLOB_LIM) begin
        glob_cnt <= glob_cnt + GLOB_W'(1);
      end
      if (glob_hit) begin
        glob_flag <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    tb_sim_watchdog_chan #(
      .LIMIT_W (LIMIT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .arm         (wd.ch_arm[i]),
      .active      (wd.ch_active[i]),
      .limit       (wd.ch_limit[i*LIMIT_W +: LIMIT_W]),
      .timeout_hit (ch_hit[i]),
      .flag        (ch_flag[i])
    );
  end

`ifdef TB_SIM_WATCHDOG_X_CHECK_EN
  logic [X_CNT_W-1:0] x_cnt;

  // X on mon_vec is counted and reported but never fails the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
    end else if (run && $isunknown(wd.mon_vec)) begin
      x_cnt <= sat_inc(x_cnt);
      $error("mon_vec has X's!");
    end
  end

  assign wd.x_err_cnt = x_cnt;
`else
  logic unused_mon;
  assign unused_mon   = ^wd.mon_vec;
  assign wd.x_err_cnt = '0;
`endif

  assign wd.ch_timeout   = ch_flag;
  assign wd.glob_timeout = glob_flag;
  assign wd.state_o      = state_q;

endmodule
